// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command handshake and status bundle for the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter with request-to-send and ack check.
// Optional: define PS2_TX_ACK_CHECK_EN to turn a high ACK sample into an error pulse.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input  logic           clk,
  input  logic           reset,
  ps2_host_tx_if.slave   bus,
  input  logic           ps2_clk_in,
  input  logic           ps2_data_in,
  output logic           ps2_clk_oe,
  output logic           ps2_data_oe
);

  localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW   = $clog2(MAXC) + 1;
  localparam int FW   = $clog2(FILTER_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity, parity_n;
  logic          clk_oe_n, data_oe_n;
  logic          done_q, done_n, error_q, error_n;
`ifdef PS2_TX_ACK_CHECK_EN
  logic          ack_bit, ack_bit_n;
`endif

  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          clk_fall;

  // Pins idle high, so the conditioning chain resets to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_in;
      data_s2 <= data_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Fires on the same cycle the filtered clock commits to 0.
  assign clk_fall = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));

  assign bus.tx_ready = (state == S_IDLE);
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_q;
  assign bus.error    = error_q;

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    parity_n  = parity;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    error_n   = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
    ack_bit_n = ack_bit;
`endif
    unique case (state)
      S_IDLE: begin
        if (bus.tx_valid) begin
          state_n  = S_INHIBIT;
          timer_n  = '0;
          shift_n  = bus.tx_data;
          parity_n = ~^bus.tx_data;
        end
      end
      S_INHIBIT: begin
        if (timer == TW'(INHIBIT_CYCLES - 1)) begin
          state_n   = S_START;
          data_oe_n = 1'b1;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      S_START: begin
        state_n   = S_SEND;
        bit_cnt_n = '0;
        timer_n   = '0;
      end
      default: begin
        // SEND, ACK and WAIT_IDLE share the timeout, which beats any edge.
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          error_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          timer_n = timer + 1'b1;
          if (state == S_SEND) begin
            if (clk_fall) begin
              bit_cnt_n = bit_cnt + 1'b1;
              case (bit_cnt)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7: begin
                  data_oe_n = ~shift[0];
                  shift_n   = {1'b0, shift[7:1]};
                end
                4'd8:    data_oe_n = ~parity;
                4'd9:    data_oe_n = 1'b0;
                default: begin
                  state_n = S_ACK;
`ifdef PS2_TX_ACK_CHECK_EN
                  ack_bit_n = data_s2;
`endif
                end
              endcase
            end
          end else if (state == S_ACK) begin
`ifdef PS2_TX_ACK_CHECK_EN
            if (ack_bit) begin
              error_n = 1'b1;
              state_n = S_IDLE;
            end else begin
              state_n = S_WAIT_IDLE;
            end
`else
            state_n = S_WAIT_IDLE;
`endif
          end else if (clk_filt && data_s2) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
    endcase
    if (state_n == S_IDLE) data_oe_n = 1'b0;
    clk_oe_n = (state_n == S_INHIBIT) || (state_n == S_START);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      parity      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bit     <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      parity      <= parity_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done_q      <= done_n;
      error_q     <= error_n;
`ifdef PS2_TX_ACK_CHECK_EN
      ack_bit     <= ack_bit_n;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a wired-AND PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INHIB = 2500;
  localparam int TMO   = 8000;
  localparam int FLEN  = 8;
  localparam int HALF  = 200;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe;
  logic ps2_clk_pin, ps2_data_pin;

  int total = 0;
  int bad = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, oe_high = 0, err_cyc = 0, send_cyc = 0;
  logic in_start = 1'b0;

  ps2_host_tx_if bus();

  assign ps2_clk_pin  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_pin = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLEN)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ps2_clk_in(ps2_clk_pin),
    .ps2_data_in(ps2_data_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  always #20 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.error) begin
      err_cnt <= err_cnt + 1;
      err_cyc <= cyc;
    end
    if (ps2_clk_oe) oe_high <= oe_high + 1;
    if (in_start && !ps2_clk_oe) send_cyc <= cyc;
    in_start <= ps2_clk_oe && ps2_data_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Device side: bits are sampled while the clock is high, after the host's update.
  task automatic dev_xfer(input bit ack_low, input int n_edges, input bit glitch,
                          output logic [10:0] frame, output bit ok);
    int n = 0;
    frame = '0;
    ok = 1'b0;
    while (!(!ps2_clk_oe && ps2_data_oe) && n < 10000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 10000) return;
    ok = 1'b1;
    repeat (HALF) @(posedge clk);
    frame[0] = ps2_data_pin;
    for (int e = 1; e <= n_edges; e++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      dev_clk = 1'b1;
      if (e <= 10) frame[e] = ps2_data_pin;
      if (e == 10 && ack_low) dev_data = 1'b0;
      if (e == 11) dev_data = 1'b1;
      if (glitch && e <= 9) begin
        repeat (HALF / 2) @(posedge clk);
        dev_clk = 1'b0;
        repeat (FLEN - 3) @(posedge clk);
        dev_clk = 1'b1;
        repeat (HALF / 2 - (FLEN - 3)) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.busy, 1'b0);
  endtask

  initial begin
    logic [10:0] frame;
    bit ok;
    int d0, e0, o0, n;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", bus.tx_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_error", bus.error, 1'b0);
    reset = 1'b0;

    // 0xF4 with normal ack
    @(posedge clk);
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'hF4);
    check("f4_clk_oe_after_accept", ps2_clk_oe, 1'b1);
    dev_xfer(1'b1, 11, 1'b0, frame, ok);
    check("f4_rts_seen", ok, 1'b1);
    check("f4_frame", frame, 11'h5E8);
    wait_idle("f4_idle");
    repeat (4) @(posedge clk);
    check("f4_done", done_cnt - d0, 1);
    check("f4_error", err_cnt - e0, 0);

    // 0xED: odd parity 1 and clock hold length
    d0 = done_cnt; o0 = oe_high;
    start_tx(8'hED);
    dev_xfer(1'b1, 11, 1'b0, frame, ok);
    check("ed_frame", frame, 11'h7DA);
    wait_idle("ed_idle");
    repeat (4) @(posedge clk);
    check("ed_clk_hold", oe_high - o0, INHIB + 1);
    check("ed_done", done_cnt - d0, 1);

    // device leaves data high on the ack clock
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h55);
    dev_xfer(1'b0, 11, 1'b0, frame, ok);
    check("nack_frame", frame, 11'h6AA);
    wait_idle("nack_idle");
    repeat (4) @(posedge clk);
`ifdef PS2_TX_ACK_CHECK_EN
    check("nack_error", err_cnt - e0, 1);
    check("nack_done", done_cnt - d0, 0);
`else
    check("nack_error", err_cnt - e0, 0);
    check("nack_done", done_cnt - d0, 1);
`endif

    // device never clocks
    start_tx(8'h12);
    n = 0;
    while (!bus.error && n < TMO + INHIB + 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_error_seen", bus.error, 1'b1);
    check("tmo_clk_oe", ps2_clk_oe, 1'b0);
    check("tmo_data_oe", ps2_data_oe, 1'b0);
    check("tmo_tx_ready", bus.tx_ready, 1'b1);
    @(posedge clk);
    check("tmo_latency", err_cyc - send_cyc, TMO);

    // reset after the 5th falling edge
    d0 = done_cnt; e0 = err_cnt;
    start_tx(8'h3C);
    dev_xfer(1'b1, 5, 1'b0, frame, ok);
    check("rst5_frame_low", frame[5:0], 6'b111000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst5_clk_oe", ps2_clk_oe, 1'b0);
    check("rst5_data_oe", ps2_data_oe, 1'b0);
    check("rst5_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (50) @(posedge clk);
    check("rst5_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    // second request while busy is dropped
    d0 = done_cnt;
    start_tx(8'hF4);
    repeat (5) @(posedge clk);
    start_tx(8'h00);
    dev_xfer(1'b1, 11, 1'b0, frame, ok);
    check("busy_frame", frame, 11'h5E8);
    wait_idle("busy_idle");
    repeat (20) @(negedge clk);
    check("busy_no_relaunch", ps2_clk_oe, 1'b0);
    check("busy_still_idle", bus.busy, 1'b0);
    check("busy_done", done_cnt - d0, 1);

    // short clock glitches between real edges
    d0 = done_cnt;
    start_tx(8'hA5);
    dev_xfer(1'b1, 11, 1'b1, frame, ok);
    check("glitch_frame", frame, 11'h74A);
    wait_idle("glitch_idle");
    repeat (4) @(posedge clk);
    check("glitch_done", done_cnt - d0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
